matmul_host_sequencer: RTL and testbench

// Host-side sequencer that drives the 8x8 int8 matmul wrapper's memory port. Sequence:
//   1. Accept a packed word stream and load it into the A BRAMs, then the B BRAMs.
//   2. Pulse-start the array and wait for done.
//   3. Read the C row BRAMs back out to a valid/ready result stream.

---
 rtl/matmul_host_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_matmul_host_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the 8x8 int8 matmul wrapper: streams A then B words into the operand
// BRAMs, kicks the array, then returns the C rows through a first-word-fall-through FIFO.
module matmul_host_sequencer #(
   parameter int DWIDTH     = 8,
   parameter int MM_SIZE    = 4,
   parameter int AWIDTH     = 7,
   parameter int A_WORDS    = 16,
   parameter int B_WORDS    = 16,
   parameter int C_WORDS    = 16,
   parameter int WR_ALIGN   = 2,
   parameter int RD_LAT     = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 1023
) (
   input  logic                      clk_mem,
   input  logic                      reset,
   input  logic                      go,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [MM_SIZE*DWIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [MM_SIZE*DWIDTH-1:0] out_data,
   output logic                      busy,
   output logic                      err_timeout,
   output logic                      enable_writing_to_mem,
   output logic                      enable_reading_from_mem,
   output logic [AWIDTH-1:0]         addr_pi,
   output logic [MM_SIZE*DWIDTH-1:0] data_pi,
   output logic                      we_a,
   output logic                      we_b,
   output logic                      we_c,
   output logic                      start_mat_mul,
   input  logic                      done_mat_mul,
   input  logic [MM_SIZE*DWIDTH-1:0] data_from_out_mat
);
   localparam int W  = MM_SIZE*DWIDTH;
   localparam int CW = $clog2(TIMEOUT+1);
   localparam int OW = $clog2(FIFO_DEPTH+RD_LAT+1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW = $clog2(WR_ALIGN+2);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_FLUSH, S_COMPUTE, S_READ, S_DRAIN
   } state_t;

   state_t            r_state, w_state_next;
   logic [AWIDTH-1:0] r_wr_cnt, w_wr_cnt_next;
   logic [AWIDTH-1:0] r_rd_cnt, w_rd_cnt_next;
   logic [CW-1:0]     r_cyc, w_cyc_next;
   logic [FW-1:0]     r_flush, w_flush_next;
   logic              r_err, w_err_next;

   logic              w_fire, w_rd_issue, w_push, w_pop;
   logic [OW-1:0]     w_inflight, w_pending;

   logic [WR_ALIGN-1:0] r_wr_vld, r_wr_isb;
   logic [W-1:0]        r_wr_data [WR_ALIGN];
   logic [RD_LAT-1:0]   r_rd_vld;

   logic [W-1:0]  r_fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [OW-1:0] r_occ;

   // Reads in flight are counted so the FIFO always has room for every issued read.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + OW'(r_rd_vld[i]);
   end
   assign w_pending = r_occ + w_inflight;

   always_comb begin
      w_state_next            = r_state;
      w_wr_cnt_next           = r_wr_cnt;
      w_rd_cnt_next           = r_rd_cnt;
      w_cyc_next              = '0;
      w_flush_next            = '0;
      w_err_next              = r_err;
      w_fire                  = 1'b0;
      w_rd_issue              = 1'b0;
      in_ready                = 1'b0;
      enable_writing_to_mem   = 1'b0;
      enable_reading_from_mem = 1'b0;
      addr_pi                 = '0;
      we_c                    = 1'b0;
      start_mat_mul           = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (go) begin
               w_state_next  = S_LOAD_A;
               w_wr_cnt_next = '0;
               w_rd_cnt_next = '0;
               w_err_next    = 1'b0;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            in_ready              = 1'b1;
            enable_writing_to_mem = 1'b1;
            addr_pi               = r_wr_cnt;
            w_fire                = in_valid;
            if (in_valid) begin
               if (r_state == S_LOAD_A && r_wr_cnt == AWIDTH'(A_WORDS-1)) begin
                  w_state_next  = S_LOAD_B;
                  w_wr_cnt_next = '0;
               end else if (r_state == S_LOAD_B && r_wr_cnt == AWIDTH'(B_WORDS-1)) begin
                  w_state_next  = S_FLUSH;
                  w_wr_cnt_next = '0;
               end else begin
                  w_wr_cnt_next = r_wr_cnt + AWIDTH'(1);
               end
            end
         end
         S_FLUSH: begin
            // Hold the write window open until the last delayed write has left the pipe.
            enable_writing_to_mem = 1'b1;
            w_flush_next          = r_flush + FW'(1);
            if (r_flush == FW'(WR_ALIGN)) begin
               w_state_next = S_COMPUTE;
               w_flush_next = '0;
            end
         end
         S_COMPUTE: begin
            start_mat_mul = 1'b1;
            we_c          = 1'b1;
            w_cyc_next    = r_cyc + CW'(1);
            if (done_mat_mul) begin
               w_state_next = S_READ;
            end else if (r_cyc == CW'(TIMEOUT-1)) begin
               w_state_next = S_READ;
               w_err_next   = 1'b1;
            end
         end
         S_READ: begin
            enable_reading_from_mem = 1'b1;
            addr_pi                 = r_rd_cnt;
            if (w_pending < OW'(FIFO_DEPTH)) begin
               w_rd_issue = 1'b1;
               if (r_rd_cnt == AWIDTH'(C_WORDS-1)) begin
                  w_state_next  = S_DRAIN;
                  w_rd_cnt_next = '0;
               end else begin
                  w_rd_cnt_next = r_rd_cnt + AWIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            if (r_occ == '0 && w_inflight == '0) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_mem) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
         r_cyc    <= '0;
         r_flush  <= '0;
         r_err    <= 1'b0;
         r_wr_vld <= '0;
         r_wr_isb <= '0;
         r_rd_vld <= '0;
         for (int i = 0; i < WR_ALIGN; i++) r_wr_data[i] <= '0;
      end else begin
         r_state     <= w_state_next;
         r_wr_cnt    <= w_wr_cnt_next;
         r_rd_cnt    <= w_rd_cnt_next;
         r_cyc       <= w_cyc_next;
         r_flush     <= w_flush_next;
         r_err       <= w_err_next;
         r_wr_vld[0] <= w_fire;
         r_wr_isb[0] <= (r_state == S_LOAD_B);
         r_wr_data[0] <= in_data;
         for (int i = 1; i < WR_ALIGN; i++) begin
            r_wr_vld[i]  <= r_wr_vld[i-1];
            r_wr_isb[i]  <= r_wr_isb[i-1];
            r_wr_data[i] <= r_wr_data[i-1];
         end
         r_rd_vld[0] <= w_rd_issue;
         for (int i = 1; i < RD_LAT; i++) r_rd_vld[i] <= r_rd_vld[i-1];
      end
   end

   assign data_pi     = r_wr_data[WR_ALIGN-1];
   assign we_a        = r_wr_vld[WR_ALIGN-1] & ~r_wr_isb[WR_ALIGN-1];
   assign we_b        = r_wr_vld[WR_ALIGN-1] &  r_wr_isb[WR_ALIGN-1];
   assign busy        = (r_state != S_IDLE);
   assign err_timeout = r_err;

   // Result FIFO: readback data lands RD_LAT cycles after its address was issued.
   assign w_push    = r_rd_vld[RD_LAT-1];
   assign out_valid = (r_occ != '0);
   assign w_pop     = out_valid & out_ready;
   assign out_data  = out_valid ? r_fifo_mem[r_rp] : '0;

   always_ff @(posedge clk_mem) begin
      if (w_push) r_fifo_mem[r_wp] <= data_from_out_mat;
   end

   always_ff @(posedge clk_mem) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_occ <= '0;
      end else begin
         if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH-1)) ? '0 : r_wp + PW'(1);
         if (w_pop)  r_rp <= (r_rp == PW'(FIFO_DEPTH-1)) ? '0 : r_rp + PW'(1);
         r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
      end
   end
endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Directed bench for matmul_host_sequencer: streaming and bubbly loads, done-driven and
// timed-out compute, back-pressured readback and reset in the middle of a load.
module tb_matmul_host_sequencer;
   logic        clk_mem = 1'b0;
   logic        reset = 1'b1;
   logic        go = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        busy, err_timeout, enable_writing_to_mem, enable_reading_from_mem;
   logic [6:0]  addr_pi;
   logic [31:0] data_pi;
   logic        we_a, we_b, we_c, start_mat_mul;
   logic        done_mat_mul = 1'b0;
   logic [31:0] data_from_out_mat = '0;

   int total = 0;
   int bad = 0;
   logic [6:0] mp_addr [4];
   logic       mp_vld  [4];

   always #5 clk_mem = ~clk_mem;

   matmul_host_sequencer dut (
      .clk_mem(clk_mem), .reset(reset), .go(go), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err_timeout(err_timeout), .enable_writing_to_mem(enable_writing_to_mem),
      .enable_reading_from_mem(enable_reading_from_mem), .addr_pi(addr_pi), .data_pi(data_pi),
      .we_a(we_a), .we_b(we_b), .we_c(we_c), .start_mat_mul(start_mat_mul),
      .done_mat_mul(done_mat_mul), .data_from_out_mat(data_from_out_mat)
   );

   function automatic logic [31:0] aword(input int n);
      return 32'hC0DE_0000 + 32'(n * 257 + 7);
   endfunction

   function automatic logic [31:0] cword(input int a);
      return 32'h5000_0000 + 32'(a) * 32'h0001_0203;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; the C BRAM answers RD_LAT=4 cycles after the address it saw.
   task automatic tick();
      @(posedge clk_mem);
      #1;
      data_from_out_mat = mp_vld[3] ? cword(int'(mp_addr[3])) : 32'hDEAD_BEEF;
      for (int i = 3; i > 0; i--) begin
         mp_addr[i] = mp_addr[i-1];
         mp_vld[i]  = mp_vld[i-1];
      end
      mp_addr[0] = addr_pi;
      mp_vld[0]  = enable_reading_from_mem;
   endtask

   // Entered on the first LOAD_A cycle; returns on the first COMPUTE cycle.
   task automatic run_load(input bit bubbly, input string tag);
      int n = 0, since = 0, c = 0, wa = 0, wb = 0, last_wa = -1, first_wb = -1;
      bit m0v = 1'b0, m0b = 1'b0, m1v = 1'b0, m1b = 1'b0, fire;
      logic [31:0] m0d = '0, m1d = '0;
      while (since < 4 && c < 200) begin
         check({tag, "_we_a"}, 32'(we_a), 32'(m1v && !m1b));
         check({tag, "_we_b"}, 32'(we_b), 32'(m1v && m1b));
         if (m1v) check({tag, "_data_pi"}, data_pi, m1d);
         if (we_a === 1'b1) begin wa++; last_wa = c; end
         if (we_b === 1'b1) begin wb++; if (first_wb < 0) first_wb = c; end
         check({tag, "_en_wr"}, 32'(enable_writing_to_mem), 32'd1);
         check({tag, "_in_ready"}, 32'(in_ready), 32'(n < 32));
         in_valid = (n < 32) && (!bubbly || (c % 2 == 0));
         in_data  = in_valid ? aword(n) : '0;
         fire = in_valid && (in_ready === 1'b1);
         if (n < 32) check({tag, "_addr"}, 32'(addr_pi), 32'(n < 16 ? n : n - 16));
         m1v = m0v; m1b = m0b; m1d = m0d;
         m0v = fire; m0b = (n >= 16); m0d = aword(n);
         if (fire) n++;
         if (n == 32) since++;
         tick();
         c++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      check({tag, "_words_accepted"}, 32'(n), 32'd32);
      check({tag, "_we_a_count"}, 32'(wa), 32'd16);
      check({tag, "_we_b_count"}, 32'(wb), 32'd16);
      if (!bubbly) check({tag, "_first_we_b_cycle"}, 32'(first_wb), 32'(last_wa + 1));
      check({tag, "_en_wr_compute"}, 32'(enable_writing_to_mem), 32'd0);
      check({tag, "_start_entry"}, 32'(start_mat_mul), 32'd1);
      check({tag, "_we_c_entry"}, 32'(we_c), 32'd1);
      check({tag, "_in_ready_compute"}, 32'(in_ready), 32'd0);
   endtask

   // Entered on the first READ cycle; returns once the sequencer is idle again.
   task automatic run_read(input int stall, input string tag);
      int got = 0, c = 0;
      out_ready = (stall == 0);
      for (int i = 0; i < stall; i++) tick();
      if (stall > 0) begin
         check({tag, "_reads_issued"}, 32'(addr_pi), 32'd8);
         check({tag, "_stall_en_rd"}, 32'(enable_reading_from_mem), 32'd1);
         check({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_stall_head"}, out_data, cword(0));
      end
      out_ready = 1'b1;
      while (got < 16 && c < 300) begin
         if (out_valid === 1'b1) begin
            check({tag, "_out_data"}, out_data, cword(got));
            got++;
         end
         tick();
         c++;
      end
      check({tag, "_words_out"}, 32'(got), 32'd16);
      while (busy === 1'b1 && c < 400) begin
         tick();
         c++;
      end
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_out_valid_end"}, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 4; i++) begin mp_addr[i] = '0; mp_vld[i] = 1'b0; end
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_strobes", {26'd0, we_a, we_b, we_c, start_mat_mul, enable_writing_to_mem,
                            enable_reading_from_mem}, 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_addr", 32'(addr_pi), 32'd0);
      check("rst_data_pi", data_pi, 32'd0);

      // Job 1: streaming load, done after 40 compute cycles, free-flowing readback.
      go = 1'b1; tick(); go = 1'b0;
      run_load(1'b0, "j1");
      for (int k = 1; k <= 41; k++) begin
         check("j1_start_high", 32'(start_mat_mul), 32'd1);
         done_mat_mul = (k == 41);
         tick();
      end
      done_mat_mul = 1'b0;
      check("j1_start_drop", 32'(start_mat_mul), 32'd0);
      check("j1_we_c_drop", 32'(we_c), 32'd0);
      check("j1_en_rd_rise", 32'(enable_reading_from_mem), 32'd1);
      check("j1_err", 32'(err_timeout), 32'd0);
      run_read(0, "j1");

      // Job 2: bubbly load, quick done, readback held off by out_ready=0.
      go = 1'b1; tick(); go = 1'b0;
      run_load(1'b1, "j2");
      for (int k = 1; k <= 6; k++) begin
         done_mat_mul = (k == 6);
         tick();
      end
      done_mat_mul = 1'b0;
      check("j2_en_rd", 32'(enable_reading_from_mem), 32'd1);
      run_read(30, "j2");

      // Job 3: done never arrives, timeout still lets the readback run.
      go = 1'b1; tick(); go = 1'b0;
      run_load(1'b0, "j3");
      check("j3_err_during", 32'(err_timeout), 32'd0);
      n = 0;
      while (start_mat_mul === 1'b1 && n < 1100) begin
         n++;
         tick();
      end
      check("j3_compute_cycles", 32'(n), 32'd1023);
      check("j3_err_set", 32'(err_timeout), 32'd1);
      check("j3_en_rd", 32'(enable_reading_from_mem), 32'd1);
      run_read(0, "j3");
      check("j3_err_sticky", 32'(err_timeout), 32'd1);

      // Job 4: next go clears the error; reset lands in LOAD_B.
      go = 1'b1; tick(); go = 1'b0;
      check("j4_err_cleared", 32'(err_timeout), 32'd0);
      check("j4_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = aword(i);
         tick();
      end
      in_valid = 1'b0;
      check("j4_load_b_addr", 32'(addr_pi), 32'd4);
      check("j4_load_b_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;
      tick();
      check("j4_rst_busy", 32'(busy), 32'd0);
      check("j4_rst_we", {30'd0, we_a, we_b}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("j4_post_busy", 32'(busy), 32'd0);
      check("j4_post_strobes", {27'd0, we_a, we_b, we_c, start_mat_mul, enable_writing_to_mem},
            32'd0);
      check("j4_post_out_valid", 32'(out_valid), 32'd0);
      check("j4_post_in_ready", 32'(in_ready), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
